snake_board_painter: RTL
========================

# snake_board_painter

Reader for the snake body memory. On each `start` it clears a one-bit-per-cell board RAM, then walks the body memory from address 0. For every active segment it paints that segment's cell. It stops at the first inactive entry. It reports the snake length and, optionally, whether any segment sits on the food cell. It sits between the snake mover (which owns the body memory write port) and the VGA/board renderer (which reads the board RAM).

## Interface
Parameters:
- `H`, default 32: board width in cells. Power of two, ≥ 2.
- `V`, default 32: board height in cells. Power of two, ≥ 2.
- Derived: `X_W = logb2(H)`, `Y_W = logb2(V)`, `ADDR_W = logb2(H*V)`.

Ports:
- `clk` in 1: single clock. All logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin one clear+paint pass. Sampled only in IDLE.
- `rd_addr` out ADDR_W: body memory read address. Synchronous RAM, 1-cycle read latency.
- `rd_data` in X_W+Y_W+1: body entry `{x[X_W], y[Y_W], active}`. `x` is the MSBs; `active` is bit 0.
- `bd_we` out 1: board RAM write enable.
- `bd_addr` out ADDR_W: board cell address `{y, x}` (= y*H + x).
- `bd_din` out 1: board cell value. 0 = empty, 1 = snake.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a pass.
- `length` out ADDR_W+1: count of active entries painted. Valid from `done` until the next `start`.
- `food_x` in X_W, `food_y` in Y_W: food cell.
- `food_hit` out 1: some active segment equals the food cell. Valid with `done`.

## Operation
- States: IDLE, CLEAR, FETCH, PAINT, DONE.
- IDLE:
  - `start=1` → CLEAR.
  - Clear `length`, `food_hit` and the cell counter.
  - While busy, `start` is ignored (no queuing).
- CLEAR, one cell per cycle for H*V cycles:
  - `bd_we=1`, `bd_din=0`, `bd_addr` = 0, 1, …, H*V−1.
  - After cell H*V−1 → FETCH.
- FETCH, one cycle: `rd_addr=0`, `bd_we=0`.
- PAINT, each cycle:
  - `rd_data` holds entry k, with k = cycles spent in PAINT; `rd_addr` = k+1.
  - If `active=1`: `bd_we=1`, `bd_addr={y,x}`, `bd_din=1`, `length` ← k+1.
  - If `active=0`: `bd_we=0` → DONE. Entries past the first inactive one are never read.
  - If entry H*V−1 is active: paint it, then → DONE (full board, `length`=H*V). `rd_addr` wraps to 0; that read is ignored.
- DONE, one cycle: `done=1`, `bd_we=0` → IDLE.
- Width rules:
  - `length` is ADDR_W+1 bits so that H*V is representable.
  - Counters wrap modulo H*V; no other arithmetic is performed.
- Duplicate segments (self-collision) paint the same cell twice; no error is flagged.
- Reset, including mid-pass: next cycle is IDLE with every output at its reset value.

## Timing
- Reset values: `rd_addr`=0, `bd_we`=0, `bd_addr`=0, `bd_din`=0, `busy`=0, `done`=0, `length`=0, `food_hit`=0.
- All outputs are registered.
- `start` sampled at edge e0:
  - CLEAR writes occupy the cycles after e0 … e(H*V−1).
  - For L < H*V, `done` is high in the cycle after edge e(H*V+L+2).
  - For L = H*V, `done` is high after edge e(2·H*V+1).
- Throughput: one body entry per cycle once PAINT is entered.
- `busy` rises the cycle after e0 and falls in the cycle after `done`.
- The caller must hold the body memory stable while `busy=1`. The pass starts after the mover's `end_shift`.

## Configuration
- `SNAKE_PAINTER_FOOD_EN` defined:
  - `food_hit` is set in PAINT when an active entry has `x==food_x && y==food_y`.
  - It is sticky until the next `start`.
- `SNAKE_PAINTER_FOOD_EN` undefined:
  - The comparator is removed and `food_hit` is tied to 0.
  - `food_x`/`food_y` stay on the port list, unused.

## Structure
- Shared package `snake_pkg`:
  - `logb2` function.
  - Body-entry field offsets (`X_LSB`, `Y_LSB`, `ACTIVE_BIT`), shared with the mover.
  - Direction constants.
  - Painter state encoding.
- One natural sub-module: the team's `StaticCounter #(H*V-1)` as the cell/entry counter, shared by CLEAR and PAINT. Its overflow ends CLEAR and marks the full-board case.

## Test plan
Use H=V=4 (16 cells) and a behavioural body RAM and board RAM.
- Body = {(2,2,1),(1,2,1),(0,2,1),(x,x,0)…}, `start` pulse → 16 zero writes, then writes to cells 10, 9, 8. `length`=3. `done` one cycle, 21 cycles after the `start` edge.
- Entry 0 inactive → clear only, no `bd_din=1` writes. `length`=0, `done` after 18 cycles.
- All 16 entries active and distinct → 16 paint writes. `length`=16. No read beyond entry 15 is used. `done` after 33 cycles.
- Food (1,2) with `SNAKE_PAINTER_FOOD_EN` and body from scenario 1 → `food_hit`=1. Food (3,3) → `food_hit`=0. Without the macro → always 0.
- `start` pulsed again mid-CLEAR → ignored; a single `done` is produced. `reset` asserted mid-PAINT → next cycle `busy`=0, `bd_we`=0, `length`=0. A new `start` completes normally.
- Body with a duplicate segment (2,2) twice → cell 10 written twice. `length` counts both entries; no error is flagged.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: definitions shared by the snake mover and the board painter.
//   logb2            - ceiling log2 for parameter derivation
//   ACTIVE_BIT/Y_LSB - body-entry field offsets; x_lsb() gives the x offset,
//                      which depends on the y field width
//   dir_e            - movement directions used by the mover
//   painter_state_e  - board painter state encoding
package snake_pkg;

  function automatic int logb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Body entry layout: {x, y, active}
  localparam int ACTIVE_BIT = 0;
  localparam int Y_LSB      = 1;

  function automatic int x_lsb(input int y_w);
    return Y_LSB + y_w;
  endfunction

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_PAINT = 3'd3,
    ST_DONE  = 3'd4
  } painter_state_e;

endpackage

// File: rtl/StaticCounter.sv
// StaticCounter: wrapping up-counter 0..MAX with synchronous clear.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clr            - synchronous clear to 0 (takes priority over en)
//   en             - advance by one, wrapping MAX -> 0
//   count          - current value
//   count_next     - value the counter moves to on the next enabled edge
//   ovf            - en while count == MAX (the wrap cycle)
module StaticCounter #(
  parameter int unsigned MAX = 15,
  localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_next = (count_q == MAX_V) ? '0 : count_q + 1'b1;
    ovf        = en && (count_q == MAX_V);
    count_d    = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_next;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/snake_board_painter.sv
// snake_board_painter: on start, clears the 1-bit-per-cell board RAM, then
// walks the snake body memory from entry 0 painting every active segment,
// stopping at the first inactive entry (or after the last entry).
// Optional food detection is built when SNAKE_PAINTER_FOOD_EN is defined;
// otherwise food_hit is tied low and food_x/food_y are unused.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - begin a clear+paint pass (accepted only when idle)
//   rd_addr / rd_data - body memory read port, 1-cycle latency, {x, y, active}
//   bd_we/addr/din    - board RAM write port, address {y, x}
//   busy, done        - pass in progress / one-cycle end-of-pass pulse
//   length            - number of active entries painted
//   food_x, food_y    - food cell; food_hit flags a segment on it
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_CLEAR | writing 0 to every board cell, one per cycle
// ST_FETCH | body read of entry 0 in flight
// ST_PAINT | entry k on rd_data, entry k+1 being read
// ST_DONE  | done pulse, back to idle
module snake_board_painter
  import snake_pkg::*;
#(
  parameter int H = 32,
  parameter int V = 32,
  localparam int X_W    = logb2(H),
  localparam int Y_W    = logb2(V),
  localparam int ADDR_W = logb2(H * V)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [X_W+Y_W:0]     rd_data,
  output logic                 bd_we,
  output logic [ADDR_W-1:0]    bd_addr,
  output logic                 bd_din,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      length,
  input  logic [X_W-1:0]       food_x,
  input  logic [Y_W-1:0]       food_y,
  output logic                 food_hit
);

  localparam int X_LSB = x_lsb(Y_W);

  painter_state_e state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              bd_we_q, bd_we_d;
  logic [ADDR_W-1:0] bd_addr_q, bd_addr_d;
  logic              bd_din_q, bd_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic              food_hit_q, food_hit_d;
  // Set when the counter wraps during PAINT: the entry now on rd_data is the
  // last one in the body memory.
  logic              full_q, full_d;

  logic              cnt_clr, cnt_en, cnt_ovf;
  logic [ADDR_W-1:0] cnt, cnt_next;

  logic              ent_active;
  logic [X_W-1:0]    ent_x;
  logic [Y_W-1:0]    ent_y;

  assign ent_active = rd_data[ACTIVE_BIT];
  assign ent_x      = rd_data[X_LSB +: X_W];
  assign ent_y      = rd_data[Y_LSB +: Y_W];

  // Shared cell/entry counter. In CLEAR it holds the cell currently being
  // written; from FETCH on it holds the body address currently being read.
  StaticCounter #(.MAX(H * V - 1)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .count      (cnt),
    .count_next (cnt_next),
    .ovf        (cnt_ovf)
  );

`ifndef SNAKE_PAINTER_FOOD_EN
  logic unused_food;
  assign unused_food = ^{food_x, food_y};
`endif

  // Every output is a flop loaded with the value belonging to the state
  // being entered, so outputs line up with state_q.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = '0;
    bd_we_d    = 1'b0;
    bd_addr_d  = bd_addr_q;
    bd_din_d   = 1'b0;
    done_d     = 1'b0;
    length_d   = length_q;
    food_hit_d = food_hit_q;
    full_d     = full_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        full_d  = 1'b0;
        if (start) begin
          state_d    = ST_CLEAR;
          bd_we_d    = 1'b1;
          bd_addr_d  = '0;
          length_d   = '0;
          food_hit_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        cnt_en = 1'b1;
        if (cnt_ovf) begin
          state_d = ST_FETCH;
        end else begin
          bd_we_d   = 1'b1;
          bd_addr_d = cnt_next;
        end
      end
      ST_FETCH: begin
        cnt_en    = 1'b1;
        state_d   = ST_PAINT;
        rd_addr_d = cnt_next;
      end
      ST_PAINT: begin
        cnt_en    = 1'b1;
        rd_addr_d = cnt_next;
        if (cnt_ovf) full_d = 1'b1;
        if (ent_active) begin
          bd_we_d   = 1'b1;
          bd_din_d  = 1'b1;
          bd_addr_d = {ent_y, ent_x};
          // cnt is k+1 modulo H*V; full_q supplies the carry for k = H*V-1
          length_d  = {full_q, cnt};
`ifdef SNAKE_PAINTER_FOOD_EN
          if (ent_x == food_x && ent_y == food_y) food_hit_d = 1'b1;
`endif
          if (full_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            rd_addr_d = '0;
          end
        end else begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          rd_addr_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifndef SNAKE_PAINTER_FOOD_EN
    food_hit_d = 1'b0;
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      bd_we_q    <= 1'b0;
      bd_addr_q  <= '0;
      bd_din_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      length_q   <= '0;
      food_hit_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      bd_we_q    <= bd_we_d;
      bd_addr_q  <= bd_addr_d;
      bd_din_q   <= bd_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      length_q   <= length_d;
      food_hit_q <= food_hit_d;
      full_q     <= full_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign bd_we    = bd_we_q;
  assign bd_addr  = bd_addr_q;
  assign bd_din   = bd_din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign length   = length_q;
  assign food_hit = food_hit_q;

endmodule
